// File: rtl/pixel_line_assembler_pkg.sv
// Shared types for the laser-line pixel path: default line geometry, the packed
// line type also used by the convolution stage, and the fill FSM state encoding.
package plaser_pkg;
   localparam int NPIX_DEF = 120;
   localparam int PIXW_DEF = 8;
   localparam int ROWW_DEF = 10;

   typedef logic [NPIX_DEF-1:0][PIXW_DEF-1:0] line_t;

   typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_e;
endpackage

// File: rtl/pixel_line_assembler_if.sv
// Pixel stream in, held line out: the camera/consumer side of the line assembler.
interface pixel_line_assembler_if
   import plaser_pkg::*;
#(
   parameter int NPIX = NPIX_DEF,
   parameter int PIXW = PIXW_DEF,
   parameter int ROWW = ROWW_DEF
) ();
   logic                        frame_start;
   logic                        pix_valid;
   logic                        pix_sol;
   logic [PIXW-1:0]             pix_data;
   logic [NPIX-1:0][PIXW-1:0]   line_data;
   logic [ROWW-1:0]             line_row;
   logic                        line_valid;
   logic                        line_ack;
   logic                        drop_err;
   logic                        short_err;

   modport master (
      output frame_start, pix_valid, pix_sol, pix_data, line_ack,
      input  line_data, line_row, line_valid, drop_err, short_err
   );

   modport slave (
      input  frame_start, pix_valid, pix_sol, pix_data, line_ack,
      output line_data, line_row, line_valid, drop_err, short_err
   );
endinterface

// File: rtl/pixel_line_assembler_hold.sv
// Hold side of the double buffer: the line seen by the consumer, its row number
// and the valid flag that stays up until the consumer acknowledges.
module line_hold_reg
   import plaser_pkg::*;
#(
   parameter int NPIX = NPIX_DEF,
   parameter int PIXW = PIXW_DEF,
   parameter int ROWW = ROWW_DEF
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      i_load,
   input  logic                      i_ack,
   input  logic [NPIX-1:0][PIXW-1:0] i_data,
   input  logic [ROWW-1:0]           i_row,
   output logic [NPIX-1:0][PIXW-1:0] o_data,
   output logic [ROWW-1:0]           o_row,
   output logic                      o_valid
);
   logic [NPIX-1:0][PIXW-1:0] r_data;
   logic [ROWW-1:0]           r_row;
   logic                      r_valid;

   // A load wins over an ack in the same cycle, so the new line stays valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data  <= '0;
         r_row   <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_row   <= i_row;
         r_valid <= 1'b1;
      end else if (i_ack) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_row   = r_row;
   assign o_valid = r_valid;
endmodule

// File: rtl/pixel_line_assembler.sv
// Assembles one scan line of pixels into a wide word and hands it to the
// parallel consumer through a double buffer, flagging dropped and short lines.
module pixel_line_assembler
   import plaser_pkg::*;
#(
   parameter int NPIX = NPIX_DEF,
   parameter int PIXW = PIXW_DEF,
   parameter int ROWW = ROWW_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   pixel_line_assembler_if.slave  bus
);
   localparam int CW = $clog2(NPIX + 1);

   fill_state_e               r_state, w_state_nxt;
   logic [CW-1:0]             r_count, w_count_nxt, w_wr_idx;
   logic [ROWW-1:0]           r_row_cnt;
   logic [NPIX-1:0][PIXW-1:0] r_fill;
   logic                      r_drop_err, r_short_err;
   logic                      w_wr_en, w_load, w_drop, w_short, w_done;
   logic                      w_line_valid, w_hold_free, w_sol_px;

   assign w_hold_free = !w_line_valid || bus.line_ack;
   assign w_sol_px    = bus.pix_valid && bus.pix_sol;

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_wr_en     = 1'b0;
      w_wr_idx    = '0;
      w_load      = 1'b0;
      w_drop      = 1'b0;
      w_short     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_sol_px) begin
               w_wr_en     = 1'b1;
               w_count_nxt = CW'(1);
               w_state_nxt = FILL;
            end
         end
         FILL: begin
            if (w_sol_px) begin
               w_short     = 1'b1;
               w_wr_en     = 1'b1;
               w_count_nxt = CW'(1);
            end else if (bus.pix_valid) begin
               w_wr_en     = 1'b1;
               w_wr_idx    = r_count;
               w_count_nxt = r_count + CW'(1);
               if (r_count == CW'(NPIX - 1)) w_state_nxt = DONE;
            end
         end
         DONE: begin
            // Transfer/drop decision uses the completed line; a coincident sol
            // pixel overwrites fill[0] on the same edge without disturbing it.
            w_done = 1'b1;
            w_load = w_hold_free;
            w_drop = !w_hold_free;
            if (w_sol_px) begin
               w_wr_en     = 1'b1;
               w_count_nxt = CW'(1);
               w_state_nxt = FILL;
            end else begin
               w_count_nxt = '0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_count_nxt = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_drop_err  <= 1'b0;
         r_short_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_drop_err  <= w_drop;
         r_short_err <= w_short;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)               r_fill <= '0;
      else if (w_wr_en)           r_fill[w_wr_idx] <= bus.pix_data;
   end

   // Dropped lines still advance the row count so rows follow camera numbering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)               r_row_cnt <= '0;
      else if (bus.frame_start)   r_row_cnt <= '0;
      else if (w_done)            r_row_cnt <= r_row_cnt + ROWW'(1);
   end

   line_hold_reg #(
      .NPIX (NPIX),
      .PIXW (PIXW),
      .ROWW (ROWW)
   ) u_hold (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_load),
      .i_ack   (bus.line_ack),
      .i_data  (r_fill),
      .i_row   (r_row_cnt),
      .o_data  (bus.line_data),
      .o_row   (bus.line_row),
      .o_valid (w_line_valid)
   );

   assign bus.line_valid = w_line_valid;
   assign bus.drop_err   = r_drop_err;
   assign bus.short_err  = r_short_err;
endmodule

// File: tb/tb_pixel_line_assembler.sv
// Directed bench for pixel_line_assembler: full lines, drops, short lines,
// ack/transfer overlap, overlong lines, frame_start and mid-line reset.
module tb_pixel_line_assembler;
   import plaser_pkg::*;

   logic clk;
   logic reset_n;
   int   n_total;
   int   n_pass;
   int   n_drop;
   int   n_short;

   line_t lnA, lnB, lnC, lnD, lnE, lnF, lnG, lnH, zero_ln;

   pixel_line_assembler_if #(.NPIX(120), .PIXW(8), .ROWW(10)) bus ();

   pixel_line_assembler #(.NPIX(120), .PIXW(8), .ROWW(10)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      n_drop  += int'(bus.drop_err);
      n_short += int'(bus.short_err);
   endtask

   task automatic send_px(input logic sol, input logic [7:0] d);
      bus.pix_valid = 1'b1;
      bus.pix_sol   = sol;
      bus.pix_data  = d;
      tick();
      bus.pix_valid = 1'b0;
      bus.pix_sol   = 1'b0;
   endtask

   task automatic send_line(input line_t ln, input int first, input int total,
                            input logic [7:0] extra);
      for (int i = first; i < total; i++) begin
         if (i < 120) send_px(i == 0, ln[i]);
         else         send_px(1'b0, extra);
      end
   endtask

   task automatic ack_cycle();
      bus.line_ack = 1'b1;
      tick();
      bus.line_ack = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_line(input string tag, input line_t obs, input line_t exp);
      int k;
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         k = 0;
         while (k < 119 && obs[k] === exp[k]) k++;
         $error("FAIL %s: pixel %0d observed %0h expected %0h", tag, k, obs[k], exp[k]);
      end
   endtask

   initial begin
      n_total = 0; n_pass = 0; n_drop = 0; n_short = 0;
      for (int k = 0; k < 120; k++) begin
         lnA[k] = 8'(k);
         lnB[k] = 8'(k) ^ 8'h3C;
         lnC[k] = 8'(2 * k);
         lnD[k] = 8'hA5;
         lnE[k] = 8'(k + 7);
         lnF[k] = 8'(k + 10);
         lnG[k] = 8'(k + 3);
         lnH[k] = 8'(255 - k);
      end
      zero_ln = '0;

      reset_n         = 1'b0;
      bus.frame_start = 1'b0;
      bus.pix_valid   = 1'b0;
      bus.pix_sol     = 1'b0;
      bus.pix_data    = '0;
      bus.line_ack    = 1'b0;
      tick(); tick(); tick();
      chk("rst_valid", 64'(bus.line_valid), 64'd0);
      chk("rst_row",   64'(bus.line_row),   64'd0);
      chk("rst_drop",  64'(bus.drop_err),   64'd0);
      chk("rst_short", 64'(bus.short_err),  64'd0);
      chk_line("rst_data", bus.line_data, zero_ln);
      reset_n = 1'b1;
      tick();
      n_drop = 0; n_short = 0;

      // Line A, then line B starting on the DONE cycle of A
      send_line(lnA, 0, 120, 8'h00);
      chk("lat_pre_valid", 64'(bus.line_valid), 64'd0);
      send_px(1'b1, lnB[0]);
      chk("a_valid", 64'(bus.line_valid), 64'd1);
      chk("a_row",   64'(bus.line_row),   64'd0);
      chk_line("a_data", bus.line_data, lnA);
      send_line(lnB, 1, 120, 8'h00);
      tick();
      chk("b_drop_pulse", 64'(bus.drop_err), 64'd1);
      chk_line("b_hold_kept", bus.line_data, lnA);
      chk("b_row_kept",   64'(bus.line_row),  64'd0);
      tick();
      chk("b_drop_end",   64'(bus.drop_err), 64'd0);
      chk("b_drop_count", 64'(n_drop),       64'd1);
      ack_cycle();
      chk("ack_clears", 64'(bus.line_valid), 64'd0);

      send_line(lnC, 0, 120, 8'h00);
      tick();
      chk("c_valid", 64'(bus.line_valid), 64'd1);
      chk("c_row",   64'(bus.line_row),   64'd2);
      chk_line("c_data", bus.line_data, lnC);

      // Short line: 50 pixels, then sol restarts with 0xA5
      ack_cycle();
      send_line(lnA, 0, 50, 8'h00);
      send_px(1'b1, 8'hA5);
      chk("short_pulse", 64'(bus.short_err), 64'd1);
      send_line(lnD, 1, 120, 8'h00);
      tick();
      chk("short_count", 64'(n_short),       64'd1);
      chk("d_valid",     64'(bus.line_valid), 64'd1);
      chk("d_row",       64'(bus.line_row),   64'd3);
      chk_line("d_data", bus.line_data, lnD);

      // Ack coincident with the next transfer
      send_line(lnE, 0, 120, 8'h00);
      bus.line_ack = 1'b1;
      tick();
      bus.line_ack = 1'b0;
      chk("e_valid", 64'(bus.line_valid), 64'd1);
      chk("e_row",   64'(bus.line_row),   64'd4);
      chk("e_nodrop", 64'(n_drop),        64'd1);
      chk_line("e_data", bus.line_data, lnE);

      // 130 pixels after sol; the extra 0xFF pixels must be ignored
      ack_cycle();
      send_line(lnF, 0, 130, 8'hFF);
      tick();
      chk("f_valid", 64'(bus.line_valid), 64'd1);
      chk("f_row",   64'(bus.line_row),   64'd5);
      chk("f_last_px", 64'(bus.line_data[119]), 64'd129);
      chk_line("f_data", bus.line_data, lnF);
      chk("f_errs", 64'(n_drop * 16 + n_short), 64'd17);

      // frame_start restarts row numbering
      bus.frame_start = 1'b1;
      ack_cycle();
      bus.frame_start = 1'b0;
      send_line(lnG, 0, 120, 8'h00);
      tick();
      chk("g_row", 64'(bus.line_row), 64'd0);
      chk_line("g_data", bus.line_data, lnG);

      // Reset in the middle of a line
      ack_cycle();
      send_line(lnH, 0, 60, 8'h00);
      reset_n = 1'b0;
      #2;
      chk("mid_rst_valid", 64'(bus.line_valid), 64'd0);
      chk_line("mid_rst_data", bus.line_data, zero_ln);
      tick();
      reset_n = 1'b1;
      tick();
      send_line(lnH, 0, 120, 8'h00);
      tick();
      chk("h_valid", 64'(bus.line_valid), 64'd1);
      chk("h_row",   64'(bus.line_row),   64'd0);
      chk_line("h_data", bus.line_data, lnH);
      chk("h_no_err", 64'(n_drop * 16 + n_short), 64'd17);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
